// File: rtl/warp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | warp_pkg: shared warp state enum, defaults and PC-update priority codes   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package warp_pkg;

  typedef enum logic [0:0] {
    WARP_IDLE = 1'b0,
    WARP_RUN  = 1'b1
  } warp_state_e;

  localparam int DEF_NUM_WARPS = 8;
  localparam int DEF_STEP      = 4;
  localparam int DEF_PC_W      = 32;

  // PC-update source, lower code wins
  localparam logic [2:0] PRIO_LAUNCH = 3'd0;
  localparam logic [2:0] PRIO_ALU    = 3'd1;
  localparam logic [2:0] PRIO_SIMT   = 3'd2;
  localparam logic [2:0] PRIO_ID     = 3'd3;
  localparam logic [2:0] PRIO_REWIND = 3'd4;
  localparam logic [2:0] PRIO_GRANT  = 3'd5;
  localparam logic [2:0] PRIO_HOLD   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/warp_pc_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | warp_pc_entry: one warp's run state, PC register and update priority mux  |
// | Optional macro: WARP_PC_ALIGN_CHECK_EN.  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module warp_pc_entry
  import warp_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int STEP = DEF_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            launch_i,
  input  logic [PC_W-1:0] launch_pc_i,
  input  logic            alu_i,
  input  logic [PC_W-1:0] alu_pc_i,
  input  logic            simt_i,
  input  logic [PC_W-1:0] simt_pc_i,
  input  logic            id_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic            rewind_i,
  input  logic            grant_i,
  input  logic            exit_i,
  output logic [PC_W-1:0] pc_o,
  output logic            run_o,
  output logic            err_o
);

  warp_state_e     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      sel;
  logic            launch_ok, alu_ok, simt_ok, id_ok;

`ifdef WARP_PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);
  logic err_q;
  logic misaligned;

  assign launch_ok = launch_i && ((launch_pc_i & ALIGN_MASK) == '0);
  assign alu_ok    = alu_i    && ((alu_pc_i    & ALIGN_MASK) == '0);
  assign simt_ok   = simt_i   && ((simt_pc_i   & ALIGN_MASK) == '0);
  assign id_ok     = id_i     && ((id_pc_i     & ALIGN_MASK) == '0);

  // Redirects to an idle warp are ignored entirely, so they cannot raise err
  assign misaligned = (launch_i && !launch_ok) ||
                      ((state_q == WARP_RUN) &&
                       ((alu_i && !alu_ok) || (simt_i && !simt_ok) || (id_i && !id_ok)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (misaligned) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign launch_ok = launch_i;
  assign alu_ok    = alu_i;
  assign simt_ok   = simt_i;
  assign id_ok     = id_i;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WARP_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    sel = PRIO_HOLD;
    if (launch_ok) begin
      sel = PRIO_LAUNCH;
    end else if (state_q == WARP_RUN) begin
      if (alu_ok)        sel = PRIO_ALU;
      else if (simt_ok)  sel = PRIO_SIMT;
      else if (id_ok)    sel = PRIO_ID;
      else if (rewind_i) sel = PRIO_REWIND;
      else if (grant_i)  sel = PRIO_GRANT;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    case (sel)
      PRIO_LAUNCH: pc_d = launch_pc_i;
      PRIO_ALU:    pc_d = alu_pc_i;
      PRIO_SIMT:   pc_d = simt_pc_i;
      PRIO_ID:     pc_d = id_pc_i;
      PRIO_REWIND: pc_d = pc_q - PC_W'(STEP);
      PRIO_GRANT:  pc_d = pc_q + PC_W'(STEP);
      default:     pc_d = pc_q;
    endcase
    if (launch_ok) begin
      state_d = WARP_RUN;
    end else if (exit_i) begin
      state_d = WARP_IDLE;
    end
  end

  assign pc_o  = pc_q;
  assign run_o = (state_q == WARP_RUN);

endmodule
`default_nettype wire

// File: rtl/warp_pc_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | warp_pc_table: per-warp PC store feeding fetch and the round-robin sched  |
// | Optional macro: WARP_PC_ALIGN_CHECK_EN.  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module warp_pc_table
  import warp_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int PC_W      = DEF_PC_W,
  parameter int STEP      = DEF_STEP,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_valid_tm,
  input  logic [WID_W-1:0]     launch_wid_tm,
  input  logic [PC_W-1:0]      launch_pc_tm,
  input  logic                 grant_valid_rr,
  input  logic [WID_W-1:0]     grant_wid_rr,
  input  logic                 rewind_valid_simt,
  input  logic [WID_W-1:0]     rewind_wid_simt,
  input  logic                 redir_valid_alu,
  input  logic [WID_W-1:0]     redir_wid_alu,
  input  logic [PC_W-1:0]      redir_pc_alu,
  input  logic                 redir_valid_simt,
  input  logic [WID_W-1:0]     redir_wid_simt,
  input  logic [PC_W-1:0]      redir_pc_simt,
  input  logic                 redir_valid_id,
  input  logic [WID_W-1:0]     redir_wid_id,
  input  logic [PC_W-1:0]      redir_pc_id,
  input  logic                 exit_valid_id,
  input  logic [WID_W-1:0]     exit_wid_id,
  output logic [PC_W-1:0]      fetch_pc_if,
  output logic                 fetch_valid_if,
  output logic [NUM_WARPS-1:0] active_mask_rr,
  output logic                 err_o
);

  function automatic logic [NUM_WARPS-1:0] onehot(input logic v, input logic [WID_W-1:0] w);
    onehot    = '0;
    onehot[w] = v;
  endfunction

  logic [NUM_WARPS-1:0] launch_oh, grant_oh, rewind_oh, alu_oh, simt_oh, id_oh, exit_oh;
  logic [NUM_WARPS-1:0] run_w, err_w;
  logic [PC_W-1:0]      pc_w [NUM_WARPS];

  assign launch_oh = onehot(launch_valid_tm,   launch_wid_tm);
  assign grant_oh  = onehot(grant_valid_rr,    grant_wid_rr);
  assign rewind_oh = onehot(rewind_valid_simt, rewind_wid_simt);
  assign alu_oh    = onehot(redir_valid_alu,   redir_wid_alu);
  assign simt_oh   = onehot(redir_valid_simt,  redir_wid_simt);
  assign id_oh     = onehot(redir_valid_id,    redir_wid_id);
  assign exit_oh   = onehot(exit_valid_id,     exit_wid_id);

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    warp_pc_entry #(
      .PC_W (PC_W),
      .STEP (STEP)
    ) u_entry (
      .clk         (clk),
      .rst         (rst),
      .launch_i    (launch_oh[g]),
      .launch_pc_i (launch_pc_tm),
      .alu_i       (alu_oh[g]),
      .alu_pc_i    (redir_pc_alu),
      .simt_i      (simt_oh[g]),
      .simt_pc_i   (redir_pc_simt),
      .id_i        (id_oh[g]),
      .id_pc_i     (redir_pc_id),
      .rewind_i    (rewind_oh[g]),
      .grant_i     (grant_oh[g]),
      .exit_i      (exit_oh[g]),
      .pc_o        (pc_w[g]),
      .run_o       (run_w[g]),
      .err_o       (err_w[g])
    );
  end

  // Read port shows the pre-update PC; the new value appears after the edge
  assign fetch_pc_if    = pc_w[grant_wid_rr];
  assign fetch_valid_if = grant_valid_rr && run_w[grant_wid_rr];
  assign active_mask_rr = run_w;
  assign err_o          = |err_w;

endmodule
`default_nettype wire
